// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated set/reset flag bank: one requester granted per cycle,
// granted command applied one edge later. Optional macro: SR_FLAG_ARB_CONFLICT_CNT_EN.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [IDXW*NREQ-1:0] idx,
    input  logic                 clr,
    output logic [NREQ-1:0]      gnt,
    output logic [NFLAG-1:0]     flags,
    output logic                 busy,
    output logic [15:0]          conflict_cnt
);
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        OP_HOLD    = 2'b00,
        OP_SET     = 2'b01,
        OP_RESET   = 2'b10,
        OP_INVALID = 2'b11
    } op_e;

    logic [PTRW-1:0]  ptr;
    logic [NREQ-1:0]  eligible;
    logic             found_any;
    logic             found_upper;
    logic [PTRW-1:0]  win_upper;
    logic [PTRW-1:0]  win_lower;
    logic [PTRW-1:0]  winner;
    logic [PTRW-1:0]  next_ptr;
    logic [1:0]       win_op;
    logic [IDXW-1:0]  win_idx;
    op_e              cap_op;
    logic [IDXW-1:0]  cap_idx;
    logic [NFLAG-1:0] flags_next;

    // A requester granted last edge is masked so a late req drop cannot double-grant.
    assign eligible = req & ~gnt;

    // Lowest eligible index at or above the pointer wins; otherwise wrap to lowest overall.
    always_comb begin
        found_any   = 1'b0;
        found_upper = 1'b0;
        win_upper   = '0;
        win_lower   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found_any = 1'b1;
                win_lower = PTRW'(i);
                if (i >= int'(ptr)) begin
                    found_upper = 1'b1;
                    win_upper   = PTRW'(i);
                end
            end
        end
        winner = found_upper ? win_upper : win_lower;
    end

    assign next_ptr = (winner == PTRW'(NREQ - 1)) ? '0 : winner + PTRW'(1);

    always_comb begin
        win_op  = '0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == PTRW'(i)) begin
                win_op  = op[2*i +: 2];
                win_idx = idx[IDXW*i +: IDXW];
            end
        end
    end

    // Indices at or beyond NFLAG never match a bit, so such commands are consumed silently.
    always_comb begin
        flags_next = flags;
        if (busy) begin
            for (int b = 0; b < NFLAG; b++) begin
                if (IDXW'(b) == cap_idx) begin
                    case (cap_op)
                        OP_SET:     flags_next[b] = 1'b1;
                        OP_RESET:   flags_next[b] = 1'b0;
                        OP_INVALID: flags_next[b] = 1'b0;
                        default:    flags_next[b] = flags[b];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            cap_op  <= OP_HOLD;
            cap_idx <= '0;
            flags   <= '0;
        end else begin
            if (found_any) begin
                gnt     <= NREQ'(1) << winner;
                busy    <= 1'b1;
                cap_op  <= op_e'(win_op);
                cap_idx <= win_idx;
                ptr     <= next_ptr;
            end else begin
                gnt  <= '0;
                busy <= 1'b0;
            end
            // Clear overrides whatever command is being applied on this edge.
            flags <= clr ? '0 : flags_next;
        end
    end

`ifdef SR_FLAG_ARB_CONFLICT_CNT_EN
    logic contended;

    assign contended = (eligible & (eligible - NREQ'(1))) != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (contended && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule
